// File: rtl/touch_adc_spi.sv
`timescale 1ns/1ps
// touch_adc_spi
// SPI initiator for an AD7843-class resistive-touch ADC. While the pen is
// down it runs an X conversion followed by a Y conversion under one chip
// select. If the pen is still down when the frame ends, it publishes the
// coordinates together with a one-cycle strobe. An idle gap follows every
// frame before the next one may start.
//
// Optional build macro: TOUCH_AVG_EN. When it is defined, every frame runs
// X,Y,X,Y, and the published coordinates are the per-axis average of the two
// readings.
//
// Ports:
//   sys_clk      in   system clock
//   iRST_n       in   asynchronous active-low reset
//   adc_penirq_n in   raw pen interrupt (asynchronous, active-low)
//   adc_dout     in   ADC serial data
//   adc_busy     in   ADC busy (not used for control)
//   adc_dclk     out  SPI clock, idles low
//   adc_din      out  SPI data to the ADC
//   adc_cs_n     out  ADC chip select, active-low
//   x_coord      out  X result bits [11:4]
//   y_coord      out  Y result bits [11:2]
//   new_coord    out  one-cycle strobe, coordinates updated
//   penirq_n     out  synchronised pen interrupt
//   transmit_en  out  high for the whole transaction
module touch_adc_spi #(
  parameter int          CLK_DIV    = 25,
  parameter int          SAMPLE_GAP = 50000,
  parameter logic [7:0]  X_CMD      = 8'h92,
  parameter logic [7:0]  Y_CMD      = 8'hD2
) (
  input  logic       sys_clk,
  input  logic       iRST_n,
  input  logic       adc_penirq_n,
  input  logic       adc_dout,
  input  logic       adc_busy,
  output logic       adc_dclk,
  output logic       adc_din,
  output logic       adc_cs_n,
  output logic [7:0] x_coord,
  output logic [9:0] y_coord,
  output logic       new_coord,
  output logic       penirq_n,
  output logic       transmit_en
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(SAMPLE_GAP + 1);
`ifdef TOUCH_AVG_EN
  localparam int NUM_CONV = 4;
`else
  localparam int NUM_CONV = 2;
`endif
  localparam logic [1:0] LAST_CONV = 2'(NUM_CONV - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    XFER     = 3'd2,
    DONE     = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t state, state_next;

  logic             pen_meta, pen_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       rise_cnt;
  logic [1:0]       conv_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       cmd_sh;
  logic [11:0]      res_sh;
  logic             dclk_q, din_q;
  logic [7:0]       x_hold, x_new;
  logic [9:0]       y_hold, y_new;
  logic             div_done, rise_evt, fall_evt, conv_end, last_conv, gap_done;
  logic [7:0]       next_cmd;
  logic             unused_busy;

`ifdef TOUCH_AVG_EN
  logic [12:0] x_acc, y_acc;
`else
  logic [11:0] x_res, y_res;
`endif

  // adc_busy is only a monitor signal, so nothing in the control logic reads it.
  assign unused_busy = adc_busy;

  assign adc_dclk = dclk_q;
  assign adc_din  = din_q;
  assign penirq_n = pen_sync;

  // During the DONE strobe the freshly computed values are shown directly.
  // At all other times the outputs show the last published coordinates.
  assign x_coord = new_coord ? x_new : x_hold;
  assign y_coord = new_coord ? y_new : y_hold;

  // Two-flop synchroniser for the asynchronous pen interrupt.
  always_ff @(posedge sys_clk or negedge iRST_n) begin
    if (!iRST_n) begin
      pen_meta <= 1'b1;
      pen_sync <= 1'b1;
    end else begin
      pen_meta <= adc_penirq_n;
      pen_sync <= pen_meta;
    end
  end

  // Decode the DCLK edges and the frame boundaries from the counters.
  // The next conversion always uses the other axis.
  always_comb begin
    div_done  = (div_cnt == DIV_W'(CLK_DIV - 1));
    rise_evt  = (state == XFER) && div_done && !dclk_q;
    fall_evt  = (state == XFER) && div_done && dclk_q;
    conv_end  = fall_evt && (rise_cnt == 5'd24);
    last_conv = (conv_idx == LAST_CONV);
    gap_done  = (gap_cnt == GAP_W'(SAMPLE_GAP - 1));
    next_cmd  = conv_idx[0] ? X_CMD : Y_CMD;
`ifdef TOUCH_AVG_EN
    x_new = x_acc[12:5];
    y_new = y_acc[12:3];
`else
    x_new = x_res[11:4];
    y_new = y_res[11:2];
`endif
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic and the outputs decoded from state. Chip select covers
  // setup and transfer. transmit_en also covers DONE, so its falling edge
  // comes one cycle after the strobe.
  always_comb begin
    state_next  = state;
    adc_cs_n    = 1'b1;
    transmit_en = 1'b0;
    new_coord   = 1'b0;
    case (state)
      IDLE: begin
        if (!pen_sync) state_next = CS_SETUP;
      end
      CS_SETUP: begin
        adc_cs_n    = 1'b0;
        transmit_en = 1'b1;
        if (div_done) state_next = XFER;
      end
      XFER: begin
        adc_cs_n    = 1'b0;
        transmit_en = 1'b1;
        if (conv_end && last_conv) state_next = DONE;
      end
      DONE: begin
        transmit_en = 1'b1;
        new_coord   = !pen_sync;
        state_next  = GAP;
      end
      GAP: begin
        if (gap_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Timing counters: the DCLK half-period divider, the rise count within a
  // conversion, the conversion index within the frame, and the idle gap.
  always_ff @(posedge sys_clk or negedge iRST_n) begin
    if (!iRST_n) begin
      div_cnt  <= '0;
      rise_cnt <= '0;
      conv_idx <= '0;
      gap_cnt  <= '0;
    end else begin
      if (state == CS_SETUP || state == XFER)
        div_cnt <= div_done ? '0 : div_cnt + 1'b1;
      else
        div_cnt <= '0;

      if (state != XFER)  rise_cnt <= '0;
      else if (conv_end)  rise_cnt <= '0;
      else if (rise_evt)  rise_cnt <= rise_cnt + 5'd1;

      if (state != XFER)  conv_idx <= '0;
      else if (conv_end)  conv_idx <= last_conv ? 2'd0 : conv_idx + 2'd1;

      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
    end
  end

  // Serial engine. DIN changes only when DCLK falls; the first command bit is
  // loaded before the first rise. Once the command has shifted out, zeros
  // follow. DOUT is captured on rises 10..21, MSB first.
  always_ff @(posedge sys_clk or negedge iRST_n) begin
    if (!iRST_n) begin
      dclk_q <= 1'b0;
      din_q  <= 1'b0;
      cmd_sh <= '0;
      res_sh <= '0;
    end else begin
      if (state != XFER)  dclk_q <= 1'b0;
      else if (rise_evt)  dclk_q <= 1'b1;
      else if (fall_evt)  dclk_q <= 1'b0;

      if (state == CS_SETUP && div_done) begin
        din_q  <= X_CMD[7];
        cmd_sh <= {X_CMD[6:0], 1'b0};
      end else if (conv_end) begin
        din_q  <= last_conv ? 1'b0 : next_cmd[7];
        cmd_sh <= last_conv ? 8'd0 : {next_cmd[6:0], 1'b0};
      end else if (fall_evt) begin
        din_q  <= cmd_sh[7];
        cmd_sh <= {cmd_sh[6:0], 1'b0};
      end else if (state != XFER && state != CS_SETUP) begin
        din_q  <= 1'b0;
        cmd_sh <= '0;
      end

      if (rise_evt && rise_cnt >= 5'd9 && rise_cnt <= 5'd20)
        res_sh <= {res_sh[10:0], adc_dout};
    end
  end

  // Store each finished conversion under its axis. In averaging builds the
  // second reading of an axis is added to the first.
  always_ff @(posedge sys_clk or negedge iRST_n) begin
    if (!iRST_n) begin
`ifdef TOUCH_AVG_EN
      x_acc <= '0;
      y_acc <= '0;
`else
      x_res <= '0;
      y_res <= '0;
`endif
    end else if (conv_end) begin
`ifdef TOUCH_AVG_EN
      if (conv_idx[0])
        y_acc <= conv_idx[1] ? y_acc + {1'b0, res_sh} : {1'b0, res_sh};
      else
        x_acc <= conv_idx[1] ? x_acc + {1'b0, res_sh} : {1'b0, res_sh};
`else
      if (conv_idx[0]) y_res <= res_sh;
      else             x_res <= res_sh;
`endif
    end
  end

  // Publish the coordinates only if the pen is still down at DONE.
  // Otherwise the frame's results are dropped.
  always_ff @(posedge sys_clk or negedge iRST_n) begin
    if (!iRST_n) begin
      x_hold <= '0;
      y_hold <= '0;
    end else if (state == DONE && !pen_sync) begin
      x_hold <= x_new;
      y_hold <= y_new;
    end
  end

endmodule

// File: tb/tb_touch_adc_spi.sv
`timescale 1ns/1ps
// tb_touch_adc_spi
// Testbench for touch_adc_spi. A behavioural ADC model decodes the command
// bytes from DIN and returns the programmed readings on DOUT. The expected
// coordinates are computed arithmetically from those readings.
module tb_touch_adc_spi;

  localparam int          CLK_DIV     = 4;
  localparam int          SAMPLE_GAP  = 40;
  localparam logic [7:0]  X_CMD       = 8'h92;
  localparam logic [7:0]  Y_CMD       = 8'hD2;
`ifdef TOUCH_AVG_EN
  localparam int NUM_CONV = 4;
`else
  localparam int NUM_CONV = 2;
`endif
  localparam int FRAME_RISES = 24 * NUM_CONV;
  localparam int WAIT_LIMIT  = 4000;

  logic       sys_clk = 1'b0;
  logic       iRST_n = 1'b0;
  logic       adc_penirq_n = 1'b1;
  logic       adc_dout = 1'b0;
  logic       adc_busy = 1'b0;
  logic       adc_dclk, adc_din, adc_cs_n;
  logic [7:0] x_coord;
  logic [9:0] y_coord;
  logic       new_coord, penirq_n, transmit_en;

  int checks_total = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  logic [7:0] exp_x = 8'd0;
  logic [9:0] exp_y = 10'd0;

  always #5 sys_clk = ~sys_clk;

  touch_adc_spi #(
    .CLK_DIV(CLK_DIV), .SAMPLE_GAP(SAMPLE_GAP), .X_CMD(X_CMD), .Y_CMD(Y_CMD)
  ) dut (
    .sys_clk(sys_clk), .iRST_n(iRST_n), .adc_penirq_n(adc_penirq_n),
    .adc_dout(adc_dout), .adc_busy(adc_busy), .adc_dclk(adc_dclk),
    .adc_din(adc_din), .adc_cs_n(adc_cs_n), .x_coord(x_coord),
    .y_coord(y_coord), .new_coord(new_coord), .penirq_n(penirq_n),
    .transmit_en(transmit_en)
  );

  // ADC model state: readings to return, plus the frame as observed on the bus.
  logic [11:0] xv [2];
  logic [11:0] yv [2];
  int          rise_in_conv = 0;
  int          frame_rises = 0;
  int          x_seen = 0, y_seen = 0, cmd_n = 0;
  int          last_frame_rises = 0, last_cmd_n = 0, late_din_hi = 0;
  logic [7:0]  cmd_rx = 8'd0;
  logic [11:0] cur_val = 12'd0;
  logic        cur_is_y = 1'b0;
  logic [7:0]  cmds [4];
  logic [7:0]  last_cmds [4];
  int          rise_next, dout_rise;
  logic [7:0]  cmd_next;

  assign rise_next = (rise_in_conv == 24) ? 1 : rise_in_conv + 1;
  assign cmd_next  = {cmd_rx[6:0], adc_din};
  assign dout_rise = rise_in_conv + 1;

  // Count the DCLK rises seen while CS is low and capture the command byte.
  // Once a command is complete, pick the reading to return for it. When CS
  // rises, the frame summary is saved and the model state is cleared.
  always @(posedge adc_dclk or posedge adc_cs_n) begin
    if (adc_cs_n) begin
      last_frame_rises <= frame_rises;
      last_cmd_n       <= cmd_n;
      last_cmds        <= cmds;
      frame_rises      <= 0;
      rise_in_conv     <= 0;
      cmd_n            <= 0;
      x_seen           <= 0;
      y_seen           <= 0;
      cur_is_y         <= 1'b0;
      cmd_rx           <= 8'd0;
    end else begin
      frame_rises  <= frame_rises + 1;
      rise_in_conv <= rise_next;
      if (rise_next <= 8) cmd_rx <= cmd_next;
      else if (adc_din)   late_din_hi <= late_din_hi + 1;
      if (rise_next == 8) begin
        if (cmd_n < 4) cmds[cmd_n[1:0]] <= cmd_next;
        cmd_n <= cmd_n + 1;
        if (cmd_next == Y_CMD) begin
          cur_is_y <= 1'b1;
          cur_val  <= yv[y_seen[0]];
          y_seen   <= y_seen + 1;
        end else begin
          cur_is_y <= 1'b0;
          cur_val  <= xv[x_seen[0]];
          x_seen   <= x_seen + 1;
        end
      end
    end
  end

  // Drive the reading after each DCLK fall so it is stable at the next rise.
  // Result bit 11 is presented for rise 10, down to bit 0 for rise 21.
  always @(negedge adc_dclk or posedge adc_cs_n) begin
    if (adc_cs_n)
      adc_dout <= 1'b0;
    else if (dout_rise >= 10 && dout_rise <= 21)
      adc_dout <= cur_val[4'(21 - dout_rise)];
    else
      adc_dout <= 1'b0;
  end

  // Count the strobes, and count any cycle where CS is low but transmit_en is not.
  int strobe_count = 0;
  int incons = 0;
  always @(negedge sys_clk) begin
    if (new_coord === 1'b1) strobe_count <= strobe_count + 1;
    if (iRST_n && adc_cs_n === 1'b0 && transmit_en !== 1'b1) incons <= incons + 1;
  end

  function automatic logic [7:0] refX(input logic [11:0] a, input logic [11:0] b);
    int s;
    s = (NUM_CONV == 4) ? (int'(a) + int'(b)) / 2 : int'(a);
    return 8'(s >> 4);
  endfunction

  function automatic logic [9:0] refY(input logic [11:0] a, input logic [11:0] b);
    int s;
    s = (NUM_CONV == 4) ? (int'(a) + int'(b)) / 2 : int'(a);
    return 10'(s >> 2);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] x0, input logic [11:0] x1,
                               input logic [11:0] y0, input logic [11:0] y1,
                               input logic pen_n);
    xv[0] = x0; xv[1] = x1;
    yv[0] = y0; yv[1] = y1;
    adc_penirq_n = pen_n;
  endtask

  task automatic waitStrobe(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      @(negedge sys_clk);
      if (new_coord === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitCsHigh(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      @(negedge sys_clk);
      if (adc_cs_n === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Run one complete pen-down transaction and check everything published at DONE.
  task automatic runTxn(input string tag, input logic [11:0] x0, input logic [11:0] x1,
                        input logic [11:0] y0, input logic [11:0] y1);
    bit seen;
    applyStimulus(x0, x1, y0, y1, 1'b0);
    exp_x = refX(x0, x1);
    exp_y = refY(y0, y1);
    waitStrobe(seen);
    checkOutput({tag, " strobe seen"}, 32'(seen), 32'd1);
    checkOutput({tag, " x_coord"}, 32'(x_coord), 32'(exp_x));
    checkOutput({tag, " y_coord"}, 32'(y_coord), 32'(exp_y));
    checkOutput({tag, " transmit_en at strobe"}, 32'(transmit_en), 32'd1);
    checkOutput({tag, " cs_n at strobe"}, 32'(adc_cs_n), 32'd1);
    checkOutput({tag, " dclk at strobe"}, 32'(adc_dclk), 32'd0);
    checkOutput({tag, " rises under cs"}, 32'(last_frame_rises), 32'(FRAME_RISES));
    checkOutput({tag, " command count"}, 32'(last_cmd_n), 32'(NUM_CONV));
    for (int i = 0; i < NUM_CONV; i++)
      checkOutput({tag, " command byte"}, 32'(last_cmds[i]),
                  32'((i % 2 == 0) ? X_CMD : Y_CMD));
    @(negedge sys_clk);
    checkOutput({tag, " transmit_en after strobe"}, 32'(transmit_en), 32'd0);
    checkOutput({tag, " strobe width"}, 32'(new_coord), 32'd0);
    checkOutput({tag, " x_coord held"}, 32'(x_coord), 32'(exp_x));
    checkOutput({tag, " y_coord held"}, 32'(y_coord), 32'(exp_y));
  endtask

  initial begin
    bit         seen;
    int         n;
    int         strobes_before;
    logic       bad;
    logic [7:0] prev_x;
    logic [9:0] prev_y;

    $display("[TB] touch_adc_spi bench, NUM_CONV=%0d", NUM_CONV);
    applyStimulus(12'h0, 12'h0, 12'h0, 12'h0, 1'b1);

    // Values while held in reset.
    repeat (3) @(negedge sys_clk);
    checkOutput("reset cs_n", 32'(adc_cs_n), 32'd1);
    checkOutput("reset dclk", 32'(adc_dclk), 32'd0);
    checkOutput("reset din", 32'(adc_din), 32'd0);
    checkOutput("reset x_coord", 32'(x_coord), 32'd0);
    checkOutput("reset y_coord", 32'(y_coord), 32'd0);
    checkOutput("reset new_coord", 32'(new_coord), 32'd0);
    checkOutput("reset transmit_en", 32'(transmit_en), 32'd0);
    checkOutput("reset penirq_n", 32'(penirq_n), 32'd1);
    iRST_n = 1'b1;

    // With the pen up, the bus must stay completely quiet.
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (adc_cs_n !== 1'b1 || adc_dclk !== 1'b0 || new_coord !== 1'b0 ||
          transmit_en !== 1'b0) bad = 1'b1;
    end
    checkOutput("pen up idle", 32'(bad), 32'd0);

    // Directed frame with known readings.
    runTxn("directed", 12'hABC, 12'hABC, 12'h123, 12'h123);

    // With the pen held down, the next frame waits out the idle gap.
    n = 1;
    while (adc_cs_n === 1'b1 && n < WAIT_LIMIT) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("sample gap", 32'(n > SAMPLE_GAP && n <= SAMPLE_GAP + 4), 32'd1);

    // Random readings.
    for (int k = 0; k < 4; k++)
      runTxn("random", 12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));

    // Averaging-style pair; the result also holds for single-pair builds.
    runTxn("pair", 12'h100, 12'h102, 12'h3F0, 12'h3F4);

    // Pen lifted during the Y conversion: the frame completes and the results are dropped.
    prev_x = exp_x;
    prev_y = exp_y;
    strobes_before = strobe_count;
    applyStimulus(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 1'b0);
    seen = 1'b0;
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      @(negedge sys_clk);
      if (cur_is_y && rise_in_conv >= 5) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("reached Y conversion", 32'(seen), 32'd1);
    adc_penirq_n = 1'b1;
    waitCsHigh(seen);
    checkOutput("pen-lift frame ended", 32'(seen), 32'd1);
    repeat (3) @(negedge sys_clk);
    checkOutput("pen-lift rises", 32'(last_frame_rises), 32'(FRAME_RISES));
    checkOutput("pen-lift no strobe", 32'(strobe_count - strobes_before), 32'd0);
    checkOutput("pen-lift x retained", 32'(x_coord), 32'(prev_x));
    checkOutput("pen-lift y retained", 32'(y_coord), 32'(prev_y));
    bad = 1'b0;
    for (int i = 0; i < SAMPLE_GAP + 60; i++) begin
      @(negedge sys_clk);
      if (adc_cs_n !== 1'b1 || transmit_en !== 1'b0) bad = 1'b1;
    end
    checkOutput("pen up after lift", 32'(bad), 32'd0);

    // Reset asserted at rise 15 of the X conversion.
    applyStimulus(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 1'b0);
    seen = 1'b0;
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      @(negedge sys_clk);
      if (frame_rises == 15) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("reached rise 15", 32'(seen), 32'd1);
    strobes_before = strobe_count;
    iRST_n = 1'b0;
    @(posedge sys_clk);
    #1;
    checkOutput("abort cs_n", 32'(adc_cs_n), 32'd1);
    checkOutput("abort dclk", 32'(adc_dclk), 32'd0);
    checkOutput("abort transmit_en", 32'(transmit_en), 32'd0);
    checkOutput("abort x_coord", 32'(x_coord), 32'd0);
    checkOutput("abort y_coord", 32'(y_coord), 32'd0);
    checkOutput("abort new_coord", 32'(new_coord), 32'd0);
    repeat (2) @(negedge sys_clk);
    checkOutput("abort no strobe", 32'(strobe_count - strobes_before), 32'd0);
    iRST_n = 1'b1;
    runTxn("after reset", 12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));

    adc_penirq_n = 1'b1;
    repeat (SAMPLE_GAP + 10) @(negedge sys_clk);
    checkOutput("din zero after command", 32'(late_din_hi), 32'd0);
    checkOutput("cs_n vs transmit_en", 32'(incons), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
